carry_lookahead_adder_32bit: RTL and testbench
==============================================

// Module: carry_lookahead_adder_32bit
// PURPOSE
//   32-bit two-level carry-lookahead adder with carry-in/carry-out, used by the ALU add/subtract path.
//   Sum and carry are computed combinationally by lookahead logic.
//   Both are captured in an output register, giving a fixed 1-cycle latency.
// PARAMETERS
//   WIDTH  32  operand width; must be a multiple of 4; 32 is the only verified value
// PORTS
//   clk     in   1      single clock, rising edge
//   rst     in   1      asynchronous, active-high reset
//   a       in   WIDTH  operand A (unsigned/two's complement agnostic)
//   b       in   WIDTH  operand B
//   c_in    in   1      carry into bit 0
//   result  out  WIDTH  registered sum bits [WIDTH-1:0] of a+b+c_in
//   c_out   out  1      registered carry out of bit WIDTH-1
//   overflow out 1      registered signed overflow (only with CLA_OVERFLOW_EN)
// BEHAVIOUR
//   - Reset: rst=1 immediately (async) forces result=0, c_out=0, overflow=0; held while rst=1.
//   - On each rising clk with rst=0: {c_out,result} <= a + b + c_in (WIDTH+1-bit exact sum).
//   - Latency 1 cycle, throughput 1 per cycle; no handshake, no enable; inputs sampled every edge.
//   - Bit level: g_i=a_i&b_i, p_i=a_i^b_i, sum_i=p_i^c_i.
//   - 4-bit group: c_{i+1}=g_i|p_i&c_i expanded flat; group G/P produced.
//   - Second level: group carries from group G/P and c_in, fully expanded (no ripple between groups).
//   - Wrap-around: result is modulo 2^WIDTH; carry out of MSB only in c_out.
//     Example: 0xFFFFFFFF + 0 + 1 -> result 0, c_out 1.
//   - c_in affects only bit-0 carry; all-propagate case (a^b all ones) must route c_in to c_out.
//   - Reset deassertion mid-stream: first edge after release registers the current inputs.
//   - No X-propagation tolerance required; inputs assumed driven.
// CONFIGURATION
//   CLA_OVERFLOW_EN defined:
//     - adds port `overflow`, registered with result.
//     - overflow = carry into MSB XOR carry out of MSB (signed overflow).
//     - reset value 0.
//   CLA_OVERFLOW_EN undefined:
//     - port `overflow` absent; no extra logic.
// STRUCTURE
//   - Shared package: WIDTH default constant (32); GROUP_W=4; typedef for {g,p} pair per group.
//   - Sub-module cla_block_4bit:
//     - inputs a[3:0], b[3:0], cin.
//     - outputs sum[3:0], group G, group P.
//     - instantiated WIDTH/4 times.
//   - Top: second-level lookahead unit (combinational) plus output register.
// TESTING
//   - rst=1 with a,b nonzero -> result=0, c_out=0 without any clock edge; stays 0 until rst drops.
//   - a=4294000000, b=967295, c_in=0 -> after 1 clk: result=4294967295 (0xFFFFFFFF), c_out=0.
//   - a=4294000000, b=967295, c_in=1 -> after 1 clk: result=0, c_out=1.
//   - a=0x0000FFFF, b=0x00000001, c_in=0 -> result=0x00010000, c_out=0; carry crosses 4 groups.
//   - a=0x7FFFFFFF, b=1, c_in=0 -> result=0x80000000, c_out=0, overflow=1 (with CLA_OVERFLOW_EN).
//   - Back-to-back random vectors each cycle vs a+b+c_in golden model, 1-cycle delayed; rst pulsed mid-run.

Source files
------------

// File: rtl/carry_lookahead_adder_32bit_pkg.sv
// ----------------------------------------------------------------------------
// carry_lookahead_adder_32bit_pkg
//   Shared constants and types for the two-level carry-lookahead adder.
//   CLA_WIDTH : default operand width (32)
//   GROUP_W   : bits per first-level lookahead block (4)
//   grp_gp_t  : {generate, propagate} pair produced by each 4-bit block
// ----------------------------------------------------------------------------
package carry_lookahead_adder_32bit_pkg;

    localparam int CLA_WIDTH = 32;
    localparam int GROUP_W   = 4;

    typedef struct packed {
        logic g;
        logic p;
    } grp_gp_t;

endpackage

// File: rtl/carry_lookahead_adder_32bit_cla_block_4bit.sv
// ----------------------------------------------------------------------------
// cla_block_4bit
//   First-level lookahead block: 4-bit sum with internal carries expanded
//   flat from cin, plus group generate/propagate for the second level.
//   Ports:
//     a, b   in  [3:0]  operand slices
//     cin    in         carry into bit 0 of this group
//     sum    out [3:0]  sum bits of this group
//     grp_g  out        group generate  (carry produced regardless of cin)
//     grp_p  out        group propagate (cin passes straight to carry out)
// ----------------------------------------------------------------------------
module cla_block_4bit
    import carry_lookahead_adder_32bit_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               grp_g,
    output logic               grp_p
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is written out as a sum of products so no carry waits on
    // the one below it.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;

endmodule

// File: rtl/carry_lookahead_adder_32bit.sv
// ----------------------------------------------------------------------------
// carry_lookahead_adder_32bit
//   Two-level carry-lookahead adder with a registered output (1-cycle
//   latency, one result per clock). {c_out, result} <= a + b + c_in.
//   Optional feature macro: CLA_OVERFLOW_EN adds a registered signed
//   overflow output.
//   Ports:
//     clk       in            rising-edge clock
//     rst       in            asynchronous active-high reset
//     a, b      in  [WIDTH]   operands
//     c_in      in            carry into bit 0
//     result    out [WIDTH]   registered sum, modulo 2^WIDTH
//     c_out     out           registered carry out of the MSB
//     overflow  out           registered signed overflow (CLA_OVERFLOW_EN only)
//   WIDTH must be a multiple of GROUP_W.
// ----------------------------------------------------------------------------
module carry_lookahead_adder_32bit
    import carry_lookahead_adder_32bit_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] result,
    output logic             c_out
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int NGROUPS = WIDTH / GROUP_W;

    grp_gp_t [NGROUPS-1:0] gp_w;
    logic    [NGROUPS:0]   grp_c;
    logic    [WIDTH-1:0]   sum_w;

    logic                  prod;
    logic                  acc;

    // First level: one lookahead block per 4-bit group.
    for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_blk
        cla_block_4bit u_blk (
            .a     (a[gi*GROUP_W +: GROUP_W]),
            .b     (b[gi*GROUP_W +: GROUP_W]),
            .cin   (grp_c[gi]),
            .sum   (sum_w[gi*GROUP_W +: GROUP_W]),
            .grp_g (gp_w[gi].g),
            .grp_p (gp_w[gi].p)
        );
    end

    // Second level: the carry into group k+1 is
    //   G[k] | P[k]G[k-1] | ... | P[k]..P[1]G[0] | P[k]..P[0]c_in
    // The loops only enumerate product terms; every group carry is a flat
    // function of the G/P vector and c_in, never of another group carry.
    always_comb begin
        grp_c    = '0;
        prod     = 1'b0;
        acc      = 1'b0;
        grp_c[0] = c_in;
        for (int k = 0; k < NGROUPS; k++) begin
            prod = c_in;
            for (int m = 0; m <= k; m++) begin
                prod = prod & gp_w[m].p;
            end
            acc = prod;
            for (int j = 0; j <= k; j++) begin
                prod = gp_w[j].g;
                for (int m = j + 1; m <= k; m++) begin
                    prod = prod & gp_w[m].p;
                end
                acc = acc | prod;
            end
            grp_c[k+1] = acc;
        end
    end

    logic [WIDTH-1:0] result_q;
    logic             c_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            c_out_q  <= 1'b0;
        end else begin
            result_q <= sum_w;
            c_out_q  <= grp_c[NGROUPS];
        end
    end

    assign result = result_q;
    assign c_out  = c_out_q;

`ifdef CLA_OVERFLOW_EN
    // The carry into the MSB is recovered from its sum bit: s = p ^ c.
    logic msb_cin_w;
    logic overflow_d;
    logic overflow_q;

    assign msb_cin_w  = sum_w[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
    assign overflow_d = msb_cin_w ^ grp_c[NGROUPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_carry_lookahead_adder_32bit.sv
// ----------------------------------------------------------------------------
// tb_carry_lookahead_adder_32bit
//   Table of directed vectors, an asynchronous reset sequence and a run of
//   back-to-back random vectors with a reset pulse in the middle. Expected
//   values are queued when stimulus is driven and popped when the registered
//   output appears one clock later.
//   Define CLA_OVERFLOW_EN to also check the overflow output.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_carry_lookahead_adder_32bit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a   = '0;
    logic [31:0] b   = '0;
    logic        c_in = 1'b0;
    logic [31:0] result;
    logic        c_out;
`ifdef CLA_OVERFLOW_EN
    logic        overflow;
`endif

    always #5 clk = ~clk;

    carry_lookahead_adder_32bit dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .result   (result),
        .c_out    (c_out)
`ifdef CLA_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Golden model: exact 33-bit sum; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input string nm);
        exp_t        e;
        logic [32:0] s;
        s      = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        e.res  = s[31:0];
        e.cout = s[32];
        e.ovf  = (x[31] == y[31]) && (s[31] != x[31]);
        e.name = nm;
        return e;
    endfunction

    task automatic check_zero(input string nm);
        n_tests++;
        if (result !== 32'd0 || c_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: result=%08h c_out=%b, required result=00000000 c_out=0",
                     nm, result, c_out);
        end
`ifdef CLA_OVERFLOW_EN
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ovf: overflow=%b, required 0", nm, overflow);
        end
`endif
    endtask

    task automatic pop_check();
        exp_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: output cycle with no queued expectation");
            return;
        end
        e = sb_q.pop_front();
        if (result !== e.res || c_out !== e.cout) begin
            n_fail++;
            $display("FAIL %s: result=%08h c_out=%b, required result=%08h c_out=%b",
                     e.name, result, c_out, e.res, e.cout);
        end else begin
            $display("[TB] %s: result=%08h c_out=%b ok", e.name, result, c_out);
        end
`ifdef CLA_OVERFLOW_EN
        n_tests++;
        if (overflow !== e.ovf) begin
            n_fail++;
            $display("FAIL %s_ovf: overflow=%b, required %b", e.name, overflow, e.ovf);
        end
`endif
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[12];
        exp_t e;

        vecs[0]  = '{32'hFFF13D80, 32'h000EC27F, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFF13D80, 32'h000EC27F, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
        vecs[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[5]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[6]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[7]  = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[8]  = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[10] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
        vecs[11] = '{32'h0FFFFFFF, 32'h00000001, 1'b0, 32'h10000000, 1'b0, 1'b0};

        // Asynchronous reset with nonzero operands, no clock edge in between.
        a = 32'h1234_5678; b = 32'h0F0F_0F0F; c_in = 1'b1;
        #1 rst = 1'b1;
        #1 check_zero("reset_async_initial");
        @(posedge clk); #1 check_zero("reset_held_edge1");
        @(posedge clk); #1 check_zero("reset_held_edge2");

        @(negedge clk);
        rst = 1'b0;

        // Directed table, one vector per cycle.
        for (int i = 0; i < 12; i++) begin
            a = vecs[i].a; b = vecs[i].b; c_in = vecs[i].cin;
            e.res = vecs[i].res; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf;
            e.name = $sformatf("vec%0d", i);
            sb_q.push_back(e);
            @(posedge clk); #1 pop_check();
            @(negedge clk);
        end

        // Register now holds a nonzero value; reset mid-cycle must clear it
        // immediately and keep it clear across edges.
        a = 32'd5; b = 32'd7; c_in = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("reset_async_midrun");
        @(posedge clk); #1 check_zero("reset_midrun_held");
        @(negedge clk);
        rst = 1'b0;
        // First edge after release registers the inputs present then.
        e.res = 32'd12; e.cout = 1'b0; e.ovf = 1'b0; e.name = "reset_release_first";
        sb_q.push_back(e);
        @(posedge clk); #1 pop_check();

        // Back-to-back random vectors with a reset pulse in the middle.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 120) begin
                rst = 1'b1;
                #1 check_zero("reset_random_pulse");
                @(negedge clk);
                rst = 1'b0;
            end
            a    = $urandom();
            b    = $urandom();
            c_in = 1'($urandom_range(0, 1));
            if (i % 16 == 0) b = ~a;   // force the all-propagate path
            sb_q.push_back(model(a, b, c_in, $sformatf("rand%0d", i)));
            @(posedge clk); #1 pop_check();
        end

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
